// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding, command bytes and frame helper.
package ps2_pkg;

    typedef logic [7:0] ps2_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_XFER,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam ps2_byte_t CMD_SET_LEDS = 8'hED;
    localparam ps2_byte_t CMD_ECHO     = 8'hEE;
    localparam ps2_byte_t CMD_RESET    = 8'hFF;
    localparam ps2_byte_t CMD_ENABLE   = 8'hF4;

    // Odd parity in bit 8, data LSB first in bits 7:0.
    function automatic logic [8:0] frame_of(input ps2_byte_t b);
        return {~^b, b};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    ps2_byte_t tx_data;
    logic      tx_valid;
    logic      tx_ready;
    logic      tx_done;
    logic      tx_error;
    logic      busy;
    logic      rx_block;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_error, busy, rx_block
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_error, busy, rx_block
    );

endinterface

// File: rtl/ps2_line_filter.sv
// 2-flop synchroniser plus FILTER_LEN-sample stability filter for a PS/2 line, with a fall strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic pin,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          fall_q;
    logic          differ;

    assign differ = (sync_q[1] != level_q);

    // Down-counter runs while the synced sample disagrees with the accepted level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= 2'b11;
            cnt_q   <= CNT_LOAD;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            fall_q <= 1'b0;
            if (!differ) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_q == '0) begin
                level_q <= sync_q[1];
                cnt_q   <= CNT_LOAD;
                fall_q  <= level_q;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one byte, reports ACK or failure.
//  state        | meaning
//  ST_IDLE      | ready for a command
//  ST_INHIBIT   | clock held low, then start bit driven
//  ST_REQ       | clock released, waiting for the first device clock
//  ST_XFER      | data bits and parity shifted out on device falls
//  ST_ACK       | stop bit released, sampling the device ack
//  ST_WAIT_IDLE | waiting for both lines high before reporting
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clock,
    input  logic          resetn,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES);
    localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state_q, state_d;
    logic [8:0]    sh_q, sh_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [IW-1:0] tmr_q, tmr_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          drv_q, drv_d;
    logic          ok_q, ok_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    data_sync_q;
    logic          data_s;
    logic          clk_lvl;
    logic          fall;
    logic          watch;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock  (clock),
        .resetn (resetn),
        .pin    (ps2_clk_in),
        .level  (clk_lvl),
        .fall   (fall)
    );

    assign data_s = data_sync_q[1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            bitcnt_q    <= '0;
            tmr_q       <= '0;
            wdog_q      <= '0;
            drv_q       <= 1'b0;
            ok_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_sync_q <= 2'b11;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bitcnt_q    <= bitcnt_d;
            tmr_q       <= tmr_d;
            wdog_q      <= wdog_d;
            drv_q       <= drv_d;
            ok_q        <= ok_d;
            done_q      <= done_d;
            err_q       <= err_d;
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        tmr_d    = tmr_q;
        wdog_d   = wdog_q;
        drv_d    = drv_q;
        ok_d     = ok_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        watch    = (state_q == ST_REQ) || (state_q == ST_XFER) ||
                   (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);

        if (watch) begin
            wdog_d = fall ? WD_LOAD : wdog_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tx.tx_valid) begin
                    sh_d     = frame_of(tx.tx_data);
                    bitcnt_d = '0;
                    tmr_d    = INH_LOAD;
                    wdog_d   = WD_LOAD;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (tmr_q == '0) state_d = ST_REQ;
                else             tmr_d   = tmr_q - 1'b1;
            end
            ST_REQ: begin
                if (fall) begin
                    drv_d    = ~sh_q[0];
                    sh_d     = {1'b0, sh_q[8:1]};
                    bitcnt_d = 4'd1;
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                if (fall) begin
                    if (bitcnt_q == 4'd9) begin
                        drv_d   = 1'b0;
                        state_d = ST_ACK;
                    end else begin
                        drv_d    = ~sh_q[0];
                        sh_d     = {1'b0, sh_q[8:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (fall) begin
                    ok_d    = ~data_s;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_lvl && data_s) begin
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog expiry overrides everything and skips the bus-idle wait.
        if (watch && (wdog_q == '0)) begin
            state_d = ST_IDLE;
            drv_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    // Pull-low enables decode straight from state so an async reset releases the bus at once.
    assign ps2_clk_oe  = (state_q == ST_INHIBIT);
    assign ps2_data_oe = ((state_q == ST_INHIBIT) && (tmr_q == '0)) ||
                         (state_q == ST_REQ) ||
                         ((state_q == ST_XFER) && drv_q);

    assign tx.tx_ready = (state_q == ST_IDLE);
    assign tx.busy     = (state_q != ST_IDLE);
    assign tx.rx_block = (state_q != ST_IDLE);
    assign tx.tx_done  = done_q;
    assign tx.tx_error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model with a clocking PS/2 device and an outcome scoreboard.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 50;
    localparam int TMO  = 600;
    localparam int HALF = 40;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0, glitch_en = 1'b0;
    logic clk_line, data_line;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    bit exp_q[$];

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .tx          (tx_if),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Wired-AND open-drain bus with pull-ups.
    assign clk_line    = ~(ps2_clk_oe | dev_clk_low);
    assign data_line   = ~(ps2_data_oe | dev_data_low);
    assign ps2_clk_in  = clk_line & ~glitch;
    assign ps2_data_in = data_line;

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected 11 bits seen by the device: start, 8 data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    always @(negedge clock) begin
        if (resetn) begin
            check("rx_block_eq_busy", tx_if.rx_block, tx_if.busy);
            check("ready_not_busy", tx_if.tx_ready, !tx_if.busy);
            check("done_err_exclusive", tx_if.tx_done & tx_if.tx_error, 1'b0);
            if (!tx_if.busy) check("idle_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
            if (tx_if.tx_done || tx_if.tx_error) begin
                if (tx_if.tx_done) done_cnt++;
                if (tx_if.tx_error) err_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 1'b1, 1'b0);
                end else begin
                    check("completion_kind", tx_if.tx_done, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit expect_ok);
        int t = 0;
        while (!tx_if.tx_ready && t < 3000) begin tick(); t++; end
        check("send_ready_wait", tx_if.tx_ready, 1'b1);
        exp_q.push_back(expect_ok);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        tick();
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic dev_run(input int max_falls, input bit ack, output logic [10:0] bits);
        int t = 0;
        bits = '1;
        while (!(clk_line && !data_line) && t < 3000) begin tick(); t++; end
        check("dev_request_seen", {clk_line, data_line}, 2'b10);
        bits[0] = data_line;
        repeat (HALF) tick();
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            if (i == max_falls) return;
            dev_clk_low = 1'b0;
            if (i <= 10) bits[i] = data_line;
            if (glitch_en) begin
                repeat (HALF / 2) tick();
                glitch = 1'b1;
                repeat (2) tick();
                glitch = 1'b0;
                repeat (HALF - HALF / 2 - 2) tick();
            end else begin
                repeat (HALF) tick();
            end
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_not_busy(input int limit);
        int t = 0;
        while (tx_if.busy && t < limit) begin tick(); t++; end
        check("busy_wait_bound", tx_if.busy, 1'b0);
        repeat (3) tick();
    endtask

    task automatic spam_aa();
        if (tx_if.busy) begin
            tx_if.tx_data  = 8'hAA;
            tx_if.tx_valid = 1'b1;
            tick();
            tx_if.tx_valid = 1'b0;
        end
    endtask

    initial begin
        logic [10:0] bits;
        int n, d0, e0, t;

        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        repeat (3) tick();
        check("rst_ready", tx_if.tx_ready, 1'b1);
        check("rst_outputs", {tx_if.tx_done, tx_if.tx_error, tx_if.busy, tx_if.rx_block}, 4'b0000);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        resetn = 1'b1;
        repeat (3) tick();

        // 1: 0xED with ACK
        d0 = done_cnt; e0 = err_cnt;
        fork
            send(CMD_SET_LEDS, 1'b1);
            dev_run(99, 1'b1, bits);
        join
        wait_not_busy(500);
        check("t1_bits_literal", bits, 11'h7DA);
        check("t1_bits_model", bits, model_frame(CMD_SET_LEDS));
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_no_error", err_cnt - e0, 0);

        // 2: 0x01, parity 0, inhibit length
        d0 = done_cnt;
        n = 0;
        fork
            send(8'h01, 1'b1);
            dev_run(99, 1'b1, bits);
            begin
                t = 0;
                while (!ps2_clk_oe && t < 100) begin tick(); t++; end
                while (ps2_clk_oe && !ps2_data_oe && n < 5 * INH) begin n++; tick(); end
            end
        join
        wait_not_busy(500);
        check("t2_inhibit_len", n, INH);
        check("t2_parity_literal", bits[9], 1'b0);
        check("t2_bits_model", bits, model_frame(8'h01));
        check("t2_done_once", done_cnt - d0, 1);

        // 3: 0xFF with NACK
        d0 = done_cnt; e0 = err_cnt;
        fork
            send(CMD_RESET, 1'b0);
            dev_run(99, 1'b0, bits);
        join
        wait_not_busy(500);
        check("t3_bits_model", bits, model_frame(CMD_RESET));
        check("t3_error_once", err_cnt - e0, 1);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_ready_back", tx_if.tx_ready, 1'b1);

        // 4: 0x00, silent device -> watchdog
        e0 = err_cnt;
        n = 0;
        fork
            send(8'h00, 1'b0);
            begin
                t = 0;
                while (!(tx_if.busy && !ps2_clk_oe && ps2_data_oe) && t < 200) begin tick(); t++; end
                while (!tx_if.tx_error && n < TMO + 100) begin tick(); n++; end
            end
        join
        check("t4_timeout_latency", n, TMO);
        check("t4_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        wait_not_busy(100);
        check("t4_error_once", err_cnt - e0, 1);

        // 5: reset after the 4th fall, then 0xF4
        d0 = done_cnt; e0 = err_cnt;
        fork
            send(CMD_ECHO, 1'b1);
            dev_run(4, 1'b1, bits);
        join
        check("t5_busy_before_reset", tx_if.busy, 1'b1);
        #3 resetn = 1'b0;
        #1;
        check("t5_async_release", {ps2_clk_oe, ps2_data_oe, tx_if.busy}, 3'b000);
        exp_q.delete();
        dev_clk_low = 1'b0;
        repeat (5) tick();
        resetn = 1'b1;
        repeat (200) tick();
        check("t5_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        fork
            send(CMD_ENABLE, 1'b1);
            dev_run(99, 1'b1, bits);
        join
        wait_not_busy(500);
        check("t5_f4_bits", bits, model_frame(CMD_ENABLE));
        check("t5_f4_done", done_cnt - d0, 1);

        // 6: tx_valid 0xAA while busy, glitches on ps2_clk_in
        d0 = done_cnt; e0 = err_cnt;
        glitch_en = 1'b1;
        fork
            send(8'h5A, 1'b1);
            dev_run(99, 1'b1, bits);
            begin
                t = 0;
                while (!tx_if.busy && t < 50) begin tick(); t++; end
                repeat (30) tick();
                spam_aa();
                repeat (270) tick();
                spam_aa();
                repeat (300) tick();
                spam_aa();
            end
        join
        glitch_en = 1'b0;
        wait_not_busy(500);
        check("t6_bits_unchanged", bits, model_frame(8'h5A));
        check("t6_done_once", done_cnt - d0, 1);
        check("t6_no_error", err_cnt - e0, 0);
        repeat (200) tick();
        check("t6_aa_not_queued", {tx_if.busy, ps2_clk_oe}, 2'b00);
        check("t6_no_extra_pulse", (done_cnt - d0) + (err_cnt - e0), 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
